// File: rtl/mix_pkg.sv
// Shared MIX definitions for the OUT responder: word geometry, opcodes, unit number and the
// responder state type.
package mix_pkg;

   localparam int unsigned WORD_W         = 31;
   localparam int unsigned ADDR_W         = 12;
   localparam int unsigned BYTE_W         = 6;
   localparam int unsigned BYTES_PER_WORD = 5;
   localparam int unsigned DATA_W         = BYTE_W * BYTES_PER_WORD;

   localparam int unsigned SIGN_BIT  = 30;
   localparam int unsigned BYTE1_MSB = 29;
   localparam int unsigned BYTE1_LSB = 24;
   localparam int unsigned BYTE5_MSB = 5;
   localparam int unsigned BYTE5_LSB = 0;

   localparam logic [5:0] JBUS = 6'd34;
   localparam logic [5:0] IN   = 6'd36;
   localparam logic [5:0] OUT  = 6'd37;
   localparam logic [5:0] JRED = 6'd38;

   localparam int unsigned LP_UNIT = 18;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StWait,
      StShift
   } out_state_e;

   // Byte 1 of the magnitude occupies the top six bits of the 30-bit data field.
   function automatic logic [BYTE_W-1:0] msb_byte(input logic [DATA_W-1:0] data);
      return data[BYTE1_MSB -: BYTE_W];
   endfunction

endpackage

// File: rtl/mix_word_serializer.sv
// Loads the 30-bit magnitude of a MIX word and emits its five 6-bit bytes, byte 1 first, on a
// valid/ready interface.
module mix_word_serializer
   import mix_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic              valid_o,
   output logic [BYTE_W-1:0] data_o,
   input  logic              ready_i,
   output logic              last_byte_o
);

   localparam logic [2:0] LastByte = 3'(BYTES_PER_WORD - 1);

   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [2:0]        byte_cnt_q, byte_cnt_d;
   logic              valid_q, valid_d;

   assign valid_o     = valid_q;
   assign data_o      = msb_byte(shreg_q);
   assign last_byte_o = (byte_cnt_q == LastByte);

   always_comb begin
      shreg_d    = shreg_q;
      byte_cnt_d = byte_cnt_q;
      valid_d    = valid_q;
      if (load_i) begin
         shreg_d    = load_data_i;
         byte_cnt_d = '0;
         valid_d    = 1'b1;
      end else if (valid_q && ready_i) begin
         // Shift the next byte up into the output slot; data_o only moves on a transfer.
         shreg_d    = shreg_q << BYTE_W;
         byte_cnt_d = byte_cnt_q + 3'd1;
         if (last_byte_o) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q    <= '0;
         byte_cnt_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         byte_cnt_q <= byte_cnt_d;
         valid_q    <= valid_d;
      end
   end

endmodule

// File: rtl/mix_out_unit.sv
// MIX OUT responder (line printer): fetches BLOCK_WORDS words starting at M and streams them
// as 6-bit characters; busy feeds JBUS/JRED.
module mix_out_unit
   import mix_pkg::*;
#(
   parameter int unsigned BLOCK_WORDS = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              reject,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [WORD_W-1:0] mem_rd_data,
   output logic              char_valid,
   output logic [BYTE_W-1:0] char_data,
   input  logic              char_ready
);

   localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(BLOCK_WORDS - 1);

   out_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic              done_q, done_d;
   logic              reject_q, reject_d;

   logic              ser_load;
   logic              ser_last;
   logic              word_done;
   logic              unused_sign;

   assign unused_sign = mem_rd_data[SIGN_BIT];
   assign word_done   = char_valid && char_ready && ser_last;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_cnt_d = word_cnt_q;
      done_d     = 1'b0;
      reject_d   = 1'b0;
      ser_load   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d     = start_addr;
               word_cnt_d = '0;
               state_d    = StFetch;
            end
         end
         StFetch: state_d = StWait;
         StWait: begin
            ser_load = 1'b1;
            state_d  = StShift;
         end
         StShift: begin
            if (word_done) begin
               if (word_cnt_q == LastWord) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  // Address wraps naturally at 4096.
                  addr_d     = addr_q + 1'b1;
                  word_cnt_d = word_cnt_q + 1'b1;
                  state_d    = StFetch;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (start && (state_q != StIdle)) begin
         reject_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         word_cnt_q <= '0;
         done_q     <= 1'b0;
         reject_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_cnt_q <= word_cnt_d;
         done_q     <= done_d;
         reject_q   <= reject_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign reject      = reject_q;
   assign mem_rd_en   = (state_q == StFetch);
   assign mem_rd_addr = addr_q;

   mix_word_serializer u_serializer (
      .clk_i       (clk),
      .rst_ni      (reset),
      .load_i      (ser_load),
      .load_data_i (mem_rd_data[DATA_W-1:0]),
      .valid_o     (char_valid),
      .data_o      (char_data),
      .ready_i     (char_ready),
      .last_byte_o (ser_last)
   );

endmodule

// File: tb/tb_mix_out_unit.sv
// Bench for mix_out_unit: directed timing/corner cases plus randomized starts and
// back-pressure, checked against a queue-based model of the OUT block transfer.
module tb_mix_out_unit;

   localparam int unsigned BW = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] start_addr;
   logic        busy, reject, done;
   logic        mem_rd_en;
   logic [11:0] mem_rd_addr;
   logic [30:0] mem_rd_data;
   logic        char_valid;
   logic [5:0]  char_data;
   logic        char_ready;

   logic [30:0] mem [4096];

   typedef struct {
      logic [5:0] ch;
      bit         last;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned addr_q[$];
   int          rd_cyc[$];
   int          cyc, t0, first_char_cyc, done_cyc, n_done, rdy_mode, base_done;
   int unsigned n_chk, n_bad;
   bit          acc_now, rej_cur, rej_next, done_cur, done_next, prev_v, prev_r;
   logic [5:0]  prev_d;

   mix_out_unit #(
      .BLOCK_WORDS (BW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_addr  (start_addr),
      .busy        (busy),
      .reject      (reject),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .char_valid  (char_valid),
      .char_data   (char_data),
      .char_ready  (char_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Byte b (0 = byte 1) of the word magnitude, by plain arithmetic.
   function automatic logic [5:0] exp_char(input logic [30:0] w, input int b);
      int unsigned mag;
      mag = int'(w[29:0]);
      return 6'((mag / (32'd1 << (6 * (4 - b)))) % 64);
   endfunction

   task automatic accept(input logic [11:0] sa);
      for (int w = 0; w < int'(BW); w++) begin
         int unsigned a;
         a = (int'(sa) + w) % 4096;
         addr_q.push_back(a);
         for (int b = 0; b < 5; b++) begin
            exp_q.push_back('{ch: exp_char(mem[a], b), last: (w == int'(BW) - 1 && b == 4)});
         end
      end
      t0 = cyc;
      first_char_cyc = -1;
      rd_cyc.delete();
      acc_now = 1'b1;
   endtask

   // Drive one cycle's inputs just after the rising edge, then check outputs at the falling edge.
   task automatic tick(input logic st, input logic [11:0] sa);
      exp_t e;
      start      = st;
      start_addr = sa;
      if (rdy_mode == 0)      char_ready = 1'b1;
      else if (rdy_mode == 1) char_ready = (cyc % 3 == 0);
      else                    char_ready = 1'($urandom_range(0, 1));
      acc_now = 1'b0;
      if (st) begin
         if (exp_q.size() == 0) accept(sa);
         else rej_next = 1'b1;
      end

      @(negedge clk);
      chk_eq("busy", busy, acc_now ? 1'b0 : (exp_q.size() != 0));
      chk_eq("reject", reject, rej_cur);
      chk_eq("done", done, done_cur);
      if (done) begin
         done_cyc = cyc;
         n_done++;
      end
      if (mem_rd_en) begin
         rd_cyc.push_back(cyc);
         if (addr_q.size() == 0) chk_eq("rd_unexpected", mem_rd_en, 1'b0);
         else chk_eq("rd_addr", mem_rd_addr, addr_q.pop_front());
      end
      if (prev_v && !prev_r) begin
         chk_eq("stall_valid", char_valid, 1'b1);
         chk_eq("stall_data", char_data, prev_d);
      end
      if (char_valid && char_ready) begin
         if (exp_q.size() == 0) begin
            chk_eq("char_unexpected", char_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk_eq("char", char_data, e.ch);
            if (first_char_cyc < 0) first_char_cyc = cyc;
            if (e.last) done_next = 1'b1;
         end
      end
      prev_v   = char_valid;
      prev_r   = char_ready;
      prev_d   = char_data;
      rej_cur  = rej_next;
      rej_next = 1'b0;
      done_cur = done_next;
      done_next = 1'b0;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t;
      n_chk = 0; n_bad = 0; cyc = 0; n_done = 0; rdy_mode = 0;
      acc_now = 0; rej_cur = 0; rej_next = 0; done_cur = 0; done_next = 0;
      prev_v = 0; prev_r = 0; prev_d = '0; first_char_cyc = -1; done_cyc = -1; t0 = 0;
      start = 1'b0; start_addr = '0; char_ready = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 31'($urandom);
      mem[100] = {1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
      mem[101] = {1'b1, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14};

      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_reject", reject, 1'b0);
      chk_eq("rst_done", done, 1'b0);
      chk_eq("rst_rd_en", mem_rd_en, 1'b0);
      chk_eq("rst_rd_addr", mem_rd_addr, 12'd0);
      chk_eq("rst_valid", char_valid, 1'b0);
      chk_eq("rst_data", char_data, 6'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Basic block with ready held high: exact cycle positions.
      tick(1'b1, 12'd100);
      t = t0;
      repeat (16) tick(1'b0, 12'd0);
      chk_eq("t1_rd_count", rd_cyc.size(), 2);
      if (rd_cyc.size() == 2) begin
         chk_eq("t1_rd0_cycle", rd_cyc[0] - t, 1);
         chk_eq("t1_rd1_cycle", rd_cyc[1] - t, 8);
      end
      chk_eq("t1_first_char", first_char_cyc - t, 3);
      chk_eq("t1_done_cycle", done_cyc - t, 15);
      chk_eq("t1_done_count", n_done, 1);

      // Same block under a 1,0,0 ready pattern.
      rdy_mode = 1;
      base_done = n_done;
      tick(1'b1, 12'd100);
      repeat (60) tick(1'b0, 12'd0);
      chk_eq("t2_drained", exp_q.size(), 0);
      chk_eq("t2_done_count", n_done - base_done, 1);

      // Address wrap 4095 -> 0 with random back-pressure.
      rdy_mode = 2;
      tick(1'b1, 12'd4095);
      repeat (80) tick(1'b0, 12'd0);
      chk_eq("t3_reads", rd_cyc.size(), 2);
      chk_eq("t3_drained", exp_q.size(), 0);

      // Second start in cycle 5 is rejected and leaves the block intact.
      rdy_mode = 0;
      base_done = n_done;
      tick(1'b1, 12'd100);
      repeat (4) tick(1'b0, 12'd0);
      tick(1'b1, 12'd500);
      repeat (12) tick(1'b0, 12'd0);
      chk_eq("t4_done_count", n_done - base_done, 1);
      chk_eq("t4_drained", exp_q.size(), 0);

      // Reset during SHIFT of the second word.
      base_done = n_done;
      tick(1'b1, 12'd100);
      repeat (10) tick(1'b0, 12'd0);
      #2 reset = 1'b0;
      #1;
      chk_eq("t5_valid_drop", char_valid, 1'b0);
      chk_eq("t5_busy_drop", busy, 1'b0);
      chk_eq("t5_rd_en_drop", mem_rd_en, 1'b0);
      exp_q.delete(); addr_q.delete();
      rej_cur = 0; rej_next = 0; done_cur = 0; done_next = 0; prev_v = 0;
      repeat (2) tick(1'b0, 12'd0);
      reset = 1'b1;
      repeat (20) tick(1'b0, 12'd0);
      chk_eq("t5_no_done", n_done - base_done, 0);
      tick(1'b1, 12'd300);
      repeat (16) tick(1'b0, 12'd0);
      chk_eq("t5_restart_done", n_done - base_done, 1);

      // Start coincident with done.
      base_done = n_done;
      tick(1'b1, 12'd100);
      repeat (14) tick(1'b0, 12'd0);
      tick(1'b1, 12'd200);
      repeat (16) tick(1'b0, 12'd0);
      chk_eq("t6_done_count", n_done - base_done, 2);
      chk_eq("t6_drained", exp_q.size(), 0);

      // Random starts and back-pressure.
      rdy_mode = 2;
      repeat (1500) tick(1'($urandom_range(0, 15) == 0), 12'($urandom));
      repeat (150) tick(1'b0, 12'd0);
      chk_eq("rand_drained", exp_q.size(), 0);
      chk_eq("rand_reads_drained", addr_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
